// File: rtl/branch_target_predictor_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch target predictor slice:
//   - bp_state_e     : sweep/run FSM state encoding
//   - BP_PC_INC      : sequential fetch increment (next instruction)
//   - BP_PC_INC_DS   : fall-through increment past the branch delay slot
//   - bp_weak_taken  : weakly-taken initial counter value for a CTR_W counter
// No ports; imported with import bp_pkg::*.
// Optional feature macro used elsewhere in the slice: BP_STATS_EN.
// -----------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned BP_PC_INC    = 4;
  localparam int unsigned BP_PC_INC_DS = 8;

  // A freshly allocated entry starts at 10...0: the lowest counter value that
  // still predicts taken, so a single not-taken outcome flips the prediction.
  function automatic int unsigned bp_weak_taken(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_target_predictor_if
// Bundles the fetch lookup, decode update and redirect signals of the branch
// target predictor. Clock and reset stay plain ports on the predictor.
//   master : front end (drives i_* lookups/updates/flush, receives o_*)
//   slave  : predictor (receives i_*, drives predictions, ready, redirect)
// Parameter ADDR_W : PC and target width.
// Macro BP_STATS_EN adds o_stat_branches / o_stat_mispredicts [31:0].
// -----------------------------------------------------------------------------
interface branch_target_predictor_if #(
  parameter int ADDR_W = 32
);

  logic              i_flush;
  logic [ADDR_W-1:0] i_fetch_pc;
  logic              o_pred_taken;
  logic [ADDR_W-1:0] o_pred_pc;
  logic              i_upd_valid;
  logic [ADDR_W-1:0] i_upd_pc;
  logic              i_upd_is_branch;
  logic              i_upd_taken;
  logic [ADDR_W-1:0] i_upd_target;
  logic              i_upd_pred_taken;
  logic [ADDR_W-1:0] i_upd_pred_pc;
  logic              o_ready;
  logic              o_mispredict;
  logic [ADDR_W-1:0] o_redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0]       o_stat_branches;
  logic [31:0]       o_stat_mispredicts;
`endif

  modport master (
    output i_flush, i_fetch_pc, i_upd_valid, i_upd_pc, i_upd_is_branch,
           i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_pc,
    input  o_pred_taken, o_pred_pc, o_ready, o_mispredict, o_redirect_pc
`ifdef BP_STATS_EN
    , input o_stat_branches, o_stat_mispredicts
`endif
  );

  modport slave (
    input  i_flush, i_fetch_pc, i_upd_valid, i_upd_pc, i_upd_is_branch,
           i_upd_taken, i_upd_target, i_upd_pred_taken, i_upd_pred_pc,
    output o_pred_taken, o_pred_pc, o_ready, o_mispredict, o_redirect_pc
`ifdef BP_STATS_EN
    , output o_stat_branches, o_stat_mispredicts
`endif
  );

endinterface

// File: rtl/branch_target_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter
// Combinational next-value of a CTR_W-bit saturating counter.
//   ctr      in  [CTR_W] : current counter value
//   inc      in  1       : 1 = count up (taken), 0 = count down (not taken)
//   ctr_next out [CTR_W] : value after one step, clamped at 0 and all-ones
// -----------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_next
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_MIN = '0;

  // Step towards taken or not-taken, holding the value at either end so a
  // strongly biased branch cannot wrap around into the opposite prediction.
  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_W'(1);
    end else begin
      if (ctr != CTR_MIN) ctr_next = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped BTB with per-entry saturating counters. Fetch gets a
// zero-latency next-PC prediction; resolved branches from decode train the
// table and produce a registered mispredict/redirect one cycle later. After
// reset or flush a sweep clears one entry per cycle before predictions turn on.
// Ports:
//   i_clk    in 1 : clock, all state changes on the rising edge
//   i_rst_n  in 1 : synchronous active-low reset
//   bus      slave modport of branch_target_predictor_if (lookup, update,
//                 flush, ready, mispredict/redirect, optional statistics)
// Parameters: ADDR_W (PC width), ENTRIES (power of two, >= 4), CTR_W (>= 1).
// Macro BP_STATS_EN: adds branch and mispredict counters on the interface.
// -----------------------------------------------------------------------------
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  branch_target_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(bp_weak_taken(CTR_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  bp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  sweep_idx_q;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic              running;
  logic [IDX_W-1:0]  fetch_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic              fetch_hit;
  logic              pred_taken;

  logic              upd_accept;
  logic              upd_branch;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              upd_mispredict;
  logic [ADDR_W-1:0] upd_redirect;
  logic [CTR_W-1:0]  ctr_next;

  logic              mispredict_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  // FSM state register: reset always lands in the sweep.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= BP_INIT;
    else          state_q <= state_d;
  end

  // Next state: the sweep finishes after visiting the last index; a flush from
  // either state restarts it, taking priority over finishing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BP_INIT: if (sweep_idx_q == LAST_IDX) state_d = BP_RUN;
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
    if (bus.i_flush) state_d = BP_INIT;
  end

  assign running     = (state_q == BP_RUN);
  assign bus.o_ready = running;

  // Sweep pointer walks every index once while in INIT. Because ENTRIES is a
  // power of two it wraps back to 0 on its own as the FSM enters RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || bus.i_flush) sweep_idx_q <= '0;
    else if (state_q == BP_INIT) sweep_idx_q <= sweep_idx_q + IDX_W'(1);
  end

  assign fetch_idx = bus.i_fetch_pc[IDX_W+1:2];
  assign fetch_tag = bus.i_fetch_pc[ADDR_W-1:IDX_W+2];
  assign fetch_hit = running && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken = fetch_hit && ctr_q[fetch_idx][CTR_W-1];

  assign bus.o_pred_taken = pred_taken;
  assign bus.o_pred_pc    = pred_taken ? target_q[fetch_idx]
                                       : bus.i_fetch_pc + ADDR_W'(BP_PC_INC);

  // Updates are only honoured while running and not being flushed; reset is
  // included so a stale RUN state cannot write during the reset cycle.
  assign upd_accept = i_rst_n && running && bus.i_upd_valid && !bus.i_flush;
  assign upd_branch = upd_accept && bus.i_upd_is_branch;
  assign upd_idx    = bus.i_upd_pc[IDX_W+1:2];
  assign upd_tag    = bus.i_upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign upd_mispredict = upd_branch &&
                          ((bus.i_upd_pred_taken != bus.i_upd_taken) ||
                           (bus.i_upd_taken && (bus.i_upd_pred_pc != bus.i_upd_target)));
  assign upd_redirect   = bus.i_upd_taken ? bus.i_upd_target
                                          : bus.i_upd_pc + ADDR_W'(BP_PC_INC_DS);

  bp_sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .ctr      (ctr_q[upd_idx]),
    .inc      (bus.i_upd_taken),
    .ctr_next (ctr_next)
  );

  // Valid bits: the sweep clears them one per cycle, a taken miss allocates,
  // and a non-branch hitting an entry kills it since the entry must be an
  // alias left over from different code at the same PC.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else if (state_q == BP_INIT) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_branch && !upd_hit && bus.i_upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end else if (upd_accept && !bus.i_upd_is_branch && upd_hit) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  // Entry payload: hits train the counter and refresh the target on taken;
  // taken misses overwrite the entry starting weakly taken. The payload needs
  // no reset because valid_q gates every use of it.
  always_ff @(posedge i_clk) begin
    if (upd_branch) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
        if (bus.i_upd_taken) target_q[upd_idx] <= bus.i_upd_target;
      end else if (bus.i_upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.i_upd_target;
        ctr_q[upd_idx]    <= CTR_WEAK_TAKEN;
      end
    end
  end

  // Registered redirect: the pulse lasts one cycle per mispredicted update,
  // and the redirect PC holds its last value between pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mispredict_q <= upd_mispredict;
      if (upd_mispredict) redirect_pc_q <= upd_redirect;
    end
  end

  assign bus.o_mispredict  = mispredict_q;
  assign bus.o_redirect_pc = redirect_pc_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Statistics survive flushes on purpose so software can sample them across
  // context switches; only reset clears them. Both wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (upd_branch)     stat_branches_q    <= stat_branches_q + 32'd1;
      if (upd_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign bus.o_stat_branches    = stat_branches_q;
  assign bus.o_stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
